// File: rtl/sar_search_pkg.sv
// Shared types for the successive-approximation search: FSM states and the
// decoded view of the external comparator's three flags.
package sar_search_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        EQ,
        GT,
        LT,
        ILLEGAL
    } cmp_e;

    // Exactly one flag must be set; anything else is a broken comparator.
    function automatic cmp_e decode_flags(input logic aeb, input logic agb, input logic alb);
        case ({aeb, agb, alb})
            3'b100:  return EQ;
            3'b010:  return GT;
            3'b001:  return LT;
            default: return ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/sar_search_mid.sv
// Overflow-free midpoint of an inclusive search window [lo, hi], with hi >= lo.
module sar_search_mid #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] mid
);

    logic [WIDTH-1:0] span;

    assign span = hi - lo;
    assign mid  = lo + (span >> 1);

endmodule

// File: rtl/sar_search.sv
// Binary search against an external comparator, one probe per clock.
// Optional probe counter output enabled by defining SAR_SEARCH_PROBE_CNT_EN.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    input  logic             cmp_aeb,
    input  logic             cmp_agb,
    input  logic             cmp_alb,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
`ifdef SAR_SEARCH_PROBE_CNT_EN
   ,output logic [$clog2(WIDTH+2)-1:0] probes
`endif
);

    localparam logic [WIDTH-1:0] MaxVal = '1;

    state_e           state;
    cmp_e             cmp;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic [WIDTH-1:0] lo_d, hi_d;
    logic [WIDTH-1:0] mid;
    logic             finish;

    // Next window is computed here so the registered trial can be the midpoint
    // of the window that will be in force during the following probe.
    always_comb begin
        cmp    = decode_flags(cmp_aeb, cmp_agb, cmp_alb);
        lo_d   = lo_q;
        hi_d   = hi_q;
        finish = 1'b0;
        if (state == IDLE && start) begin
            lo_d = '0;
            hi_d = MaxVal;
        end else if (state == PROBE) begin
            unique case (cmp)
                EQ:      finish = 1'b1;
                GT:      if (trial == hi_q) finish = 1'b1; else lo_d = trial + 1'b1;
                LT:      if (trial == lo_q) finish = 1'b1; else hi_d = trial - 1'b1;
                default: finish = 1'b1;
            endcase
        end
    end

    sar_search_mid #(
        .WIDTH (WIDTH)
    ) u_mid (
        .lo  (lo_d),
        .hi  (hi_d),
        .mid (mid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            trial  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
            lo_q   <= '0;
            hi_q   <= '0;
`ifdef SAR_SEARCH_PROBE_CNT_EN
            probes <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= PROBE;
                        busy  <= 1'b1;
                        found <= 1'b0;
                        err   <= 1'b0;
                        trial <= mid;
                        lo_q  <= lo_d;
                        hi_q  <= hi_d;
`ifdef SAR_SEARCH_PROBE_CNT_EN
                        probes <= '0;
`endif
                    end
                end
                PROBE: begin
                    lo_q <= lo_d;
                    hi_q <= hi_d;
`ifdef SAR_SEARCH_PROBE_CNT_EN
                    probes <= probes + 1'b1;
`endif
                    if (cmp == EQ) begin
                        result <= trial;
                        found  <= 1'b1;
                    end
                    if (cmp == ILLEGAL) begin
                        err <= 1'b1;
                    end
                    if (finish) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        trial <= mid;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: comparator driven from a target register,
// expectations from a plain-arithmetic binary-search model.
module tb_sar_search;

    localparam int W         = 4;
    localparam int MODE_CMP  = 0;
    localparam int MODE_GT   = 1;
    localparam int MODE_EQGT = 2;
    localparam int MODE_NONE = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] trial, result;
    logic         cmp_aeb, cmp_agb, cmp_alb;
    logic         busy, done, found, err;
`ifdef SAR_SEARCH_PROBE_CNT_EN
    logic [$clog2(W+2)-1:0] probes;
`endif

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] target = '0;
    int           mode = MODE_CMP;
    logic [2:0]   flags;

    always #5 clk = ~clk;

    always_comb begin
        flags = 3'b000;
        case (mode)
            MODE_CMP:  flags = {target == trial, target > trial, target < trial};
            MODE_GT:   flags = 3'b010;
            MODE_EQGT: flags = 3'b110;
            default:   flags = 3'b000;
        endcase
    end
    assign {cmp_aeb, cmp_agb, cmp_alb} = flags;

    sar_search #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .trial   (trial),
        .cmp_aeb (cmp_aeb),
        .cmp_agb (cmp_agb),
        .cmp_alb (cmp_alb),
        .busy    (busy),
        .done    (done),
        .found   (found),
        .err     (err),
        .result  (result)
`ifdef SAR_SEARCH_PROBE_CNT_EN
       ,.probes  (probes)
`endif
    );

    // Observations from one search.
    int   obs_trials[$];
    bit   obs_timeout, obs_pulse_ok;
    logic obs_found, obs_err;
    logic [W-1:0] obs_result;
    int   obs_probes;

    // Expectations from the model.
    int   exp_trials[$];
    bit   exp_found, exp_err;
    int   exp_result = 0;

    task automatic ref_search(input int tgt, input int md);
        int lo = 0;
        int hi = (1 << W) - 1;
        int t;
        bit gt;
        exp_trials.delete();
        exp_found = 0;
        exp_err   = 0;
        if (md == MODE_EQGT || md == MODE_NONE) begin
            exp_trials.push_back((lo + hi) / 2);
            exp_err = 1;
            return;
        end
        forever begin
            t = (lo + hi) / 2;
            exp_trials.push_back(t);
            gt = (md == MODE_GT) || (tgt > t);
            if (md == MODE_CMP && tgt == t) begin
                exp_found  = 1;
                exp_result = t;
                break;
            end else if (gt) begin
                if (t == hi) break;
                lo = t + 1;
            end else begin
                if (t == lo) break;
                hi = t - 1;
            end
        end
    endtask

    task automatic do_search(input int tgt, input int md, input bit hold_start);
        target = W'(tgt);
        mode   = md;
        obs_trials.delete();
        obs_timeout = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busy) obs_trials.push_back(int'(trial));
            if (done) begin
                obs_timeout = 0;
                break;
            end
            @(negedge clk);
        end
        start      = 1'b0;
        obs_found  = found;
        obs_err    = err;
        obs_result = result;
`ifdef SAR_SEARCH_PROBE_CNT_EN
        obs_probes = int'(probes);
`else
        obs_probes = obs_trials.size();
`endif
        @(negedge clk);
        obs_pulse_ok = !done && !busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({trial, result, busy, done, found, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got trial=%0d result=%0d busy=%b done=%b found=%b err=%b, required all 0",
                     trial, result, busy, done, found, err);
        end
`ifdef SAR_SEARCH_PROBE_CNT_EN
        checks++;
        if (probes !== '0) begin
            errors++;
            $display("FAIL reset_probes: got %0d required 0", probes);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_result = 0;
    endtask

    task automatic test_directed();
        int tgts[4]  = '{7, 15, 0, 0};
        int modes[4] = '{MODE_CMP, MODE_CMP, MODE_CMP, MODE_GT};
        for (int i = 0; i < 4; i++) begin
            ref_search(tgts[i], modes[i]);
            do_search(tgts[i], modes[i], 0);
            checks++;
            if (obs_timeout || obs_trials != exp_trials) begin
                errors++;
                $display("FAIL directed_trials[%0d]: got %p (timeout=%0d) required %p",
                         i, obs_trials, obs_timeout, exp_trials);
            end
            checks++;
            if ({obs_found, obs_err} !== {exp_found, exp_err} || int'(obs_result) != exp_result) begin
                errors++;
                $display("FAIL directed_status[%0d]: got found=%b err=%b result=%0d required %b %b %0d",
                         i, obs_found, obs_err, obs_result, exp_found, exp_err, exp_result);
            end
            checks++;
            if (obs_probes != exp_trials.size() || !obs_pulse_ok) begin
                errors++;
                $display("FAIL directed_probes[%0d]: got probes=%0d pulse_ok=%0d required %0d 1",
                         i, obs_probes, obs_pulse_ok, exp_trials.size());
            end
        end
        // Idle hold: trial and result stay put while the comparator input moves.
        target = 4'd9;
        repeat (3) @(negedge clk);
        checks++;
        if (int'(trial) != exp_trials[exp_trials.size()-1] || int'(result) != exp_result || busy) begin
            errors++;
            $display("FAIL idle_hold: got trial=%0d result=%0d busy=%b required %0d %0d 0",
                     trial, result, busy, exp_trials[exp_trials.size()-1], exp_result);
        end
    endtask

    task automatic test_illegal();
        int modes[2] = '{MODE_EQGT, MODE_NONE};
        for (int i = 0; i < 2; i++) begin
            ref_search(3, modes[i]);
            do_search(3, modes[i], 0);
            checks++;
            if (obs_timeout || obs_trials != exp_trials || obs_err !== 1'b1 || obs_found !== 1'b0
                || obs_probes != 1 || !obs_pulse_ok) begin
                errors++;
                $display("FAIL illegal[%0d]: got trials=%p err=%b found=%b probes=%0d pulse_ok=%0d required %p 1 0 1 1",
                         i, obs_trials, obs_err, obs_found, obs_probes, obs_pulse_ok, exp_trials);
            end
            checks++;
            if (int'(obs_result) != exp_result) begin
                errors++;
                $display("FAIL illegal_result_hold[%0d]: got %0d required %0d", i, obs_result, exp_result);
            end
        end
    endtask

    task automatic test_start_held();
        int tgt = int'($urandom_range(0, 15));
        ref_search(tgt, MODE_CMP);
        do_search(tgt, MODE_CMP, 1);
        checks++;
        if (obs_timeout || obs_trials != exp_trials || obs_found !== 1'b1 || int'(obs_result) != tgt) begin
            errors++;
            $display("FAIL start_held: got trials=%p found=%b result=%0d required %p 1 %0d",
                     obs_trials, obs_found, obs_result, exp_trials, tgt);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy || done) begin
            errors++;
            $display("FAIL start_held_restart: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_random();
        int tgt, md, pick;
        for (int i = 0; i < 30; i++) begin
            tgt  = int'($urandom_range(0, 15));
            pick = int'($urandom_range(0, 9));
            md   = (pick < 7) ? MODE_CMP : (pick == 7) ? MODE_GT : (pick == 8) ? MODE_EQGT : MODE_NONE;
            ref_search(tgt, md);
            do_search(tgt, md, 0);
            checks++;
            if (obs_timeout || obs_trials != exp_trials || obs_found !== exp_found
                || obs_err !== exp_err || int'(obs_result) != exp_result
                || obs_probes != exp_trials.size() || !obs_pulse_ok) begin
                errors++;
                $display("FAIL random[%0d] tgt=%0d mode=%0d: got trials=%p found=%b err=%b result=%0d probes=%0d required %p %b %b %0d %0d",
                         i, tgt, md, obs_trials, obs_found, obs_err, obs_result, obs_probes,
                         exp_trials, exp_found, exp_err, exp_result, exp_trials.size());
            end
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done = 0;
        target = '0;
        mode   = MODE_CMP;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({trial, result, busy, done, found, err} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got trial=%0d result=%0d busy=%b done=%b found=%b err=%b, required all 0",
                     trial, result, busy, done, found, err);
        end
        exp_result = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: got done pulse, required none");
        end
        ref_search(0, MODE_CMP);
        do_search(0, MODE_CMP, 0);
        checks++;
        if (obs_timeout || obs_trials != exp_trials || obs_found !== 1'b1 || obs_result !== '0
            || obs_probes != 4) begin
            errors++;
            $display("FAIL abort_fresh_search: got trials=%p found=%b result=%0d probes=%0d required %p 1 0 4",
                     obs_trials, obs_found, obs_result, obs_probes, exp_trials);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_start_held();
        test_random();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
